// File: rtl/fdivsqrt_intresult_pkg.sv
// Shared configuration for the divider integer-result back end.
// Holds the core widths, the derived iteration-counter width and the operation-flag bundle.
package fdivsqrt_intresult_pkg;

    localparam int unsigned CFG_XLEN    = 64;  // integer result width (32 or 64)
    localparam int unsigned CFG_DIVB    = 64;  // quotient fraction bits
    localparam int unsigned CFG_LOGR    = 1;   // log2 of the radix (1 or 2)
    localparam int unsigned CFG_DIVA    = 1;   // integer bits ahead of the quotient point
    localparam int unsigned CFG_DIVBLEN = $clog2(CFG_DIVB + 1);

    // Operation flags carried from the first stage into the second.
    typedef struct packed {
        logic rem_op;    // remainder requested instead of quotient
        logic as_neg;    // remainder takes the dividend's negative sign
        logic neg_quot;  // quotient is negative
        logic b_zero;    // divide by zero
        logic altb;      // |A| < |B|: quotient 0, remainder A
        logic w64;       // 32-bit op on a 64-bit core
    } op_flags_t;

endpackage

// File: rtl/fdivsqrt_intresult_if.sv
// Handshake/data bundle for fdivsqrt_intresult.
// master: drives the residual, quotient, operand and flag inputs plus in_valid/out_ready.
// slave : the result stage; drives in_ready, out_valid, Result and Sticky.
interface fdivsqrt_intresult_if
    import fdivsqrt_intresult_pkg::*;
#(
    parameter int unsigned XLEN = CFG_XLEN,
    parameter int unsigned DIVb = CFG_DIVB
);
    localparam int unsigned DIVBLEN = $clog2(DIVb + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DIVb+3:0]   WS;
    logic [DIVb+3:0]   WC;
    logic [DIVb+3:0]   D;
    logic [DIVb:0]     U;
    logic [DIVb:0]     UM;
    logic [DIVBLEN:0]  n;
    logic [DIVBLEN:0]  m;
    logic [XLEN-1:0]   A;
    logic              RemOp;
    logic              As;
    logic              NegQuot;
    logic              BZero;
    logic              ALTB;
    logic              W64;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   Result;
    logic              Sticky;

    modport master (
        output in_valid, WS, WC, D, U, UM, n, m, A,
               RemOp, As, NegQuot, BZero, ALTB, W64, out_ready,
        input  in_ready, out_valid, Result, Sticky
    );

    modport slave (
        input  in_valid, WS, WC, D, U, UM, n, m, A,
               RemOp, As, NegQuot, BZero, ALTB, W64, out_ready,
        output in_ready, out_valid, Result, Sticky
    );

endinterface

// File: rtl/fdivsqrt_intresult_stage.sv
// Generic pipeline register: a valid bit plus a data word.
// Ports: clk, reset (sync, active high), clear (drops valid only), en (stage advances),
//        in_valid/in_data (upstream), out_valid/out_data (registered).
module fdivsqrt_intresult_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (clear) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= in_valid;
            end
            // Data only moves with a real transfer; a clear leaves it as it was.
            if (en && in_valid && !clear) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/fdivsqrt_intresult.sv
// Integer quotient/remainder back end of the digit-recurrence divider.
// Stage 1 resolves the carry-save residual, picks U or U-1 and forms the corrected
// remainder; stage 2 applies signs, the normalising shift and the special cases.
// Ports: clk, reset (sync, active high), flush (kill in-flight ops),
//        bus (slave modport: input handshake/data, output handshake/Result/Sticky).
module fdivsqrt_intresult
    import fdivsqrt_intresult_pkg::*;
#(
    parameter int unsigned XLEN = CFG_XLEN,
    parameter int unsigned DIVb = CFG_DIVB,
    parameter int unsigned LOGR = CFG_LOGR,
    parameter int unsigned DIVa = CFG_DIVA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    fdivsqrt_intresult_if.slave bus
);

    localparam int unsigned DIVBLEN = $clog2(DIVb + 1);
    localparam int unsigned W       = DIVb + 4;
    localparam int unsigned SW      = DIVBLEN + 1;
    localparam int unsigned S1W     = (DIVb + 1) + W + 1 + $bits(op_flags_t) + XLEN + SW;
    localparam int unsigned S2W     = XLEN + 1;

    localparam logic [SW-1:0] DivaC = SW'(DIVa);
    localparam logic [SW-1:0] DivbC = SW'(DIVb);

    // Handshake
    logic s1_valid, s2_valid, s1_adv;

    assign s1_adv        = ~s2_valid | bus.out_ready;
    assign bus.in_ready  = ~s1_valid | s1_adv;
    assign bus.out_valid = s2_valid;

    // Stage 1: residual sign, quotient select, remainder correction, shift amount
    logic signed [W-1:0] sum;
    logic [W-1:0]        sum_sh;
    logic                neg;
    logic [DIVb:0]       qsel;
    logic [W-1:0]        rem;
    logic                sticky;
    logic [SW-1:0]       n_scaled;
    logic [SW-1:0]       shift;
    op_flags_t           flags;
    logic [S1W-1:0]      s1_in, s1_data;

    always_comb begin
        flags    = {bus.RemOp, bus.As, bus.NegQuot, bus.BZero, bus.ALTB, bus.W64};
        sum      = bus.WS + bus.WC;
        neg      = sum[W-1];
        qsel     = neg ? bus.UM : bus.U;
        // Halve before correcting: the last iteration left the residual one digit ahead.
        sum_sh   = sum >>> LOGR;
        rem      = sum_sh + (neg ? bus.D : '0);
        sticky   = |sum;
        n_scaled = (LOGR == 2) ? {bus.n[SW-2:0], 1'b0} : bus.n;
        shift    = flags.rem_op ? (bus.m + DivaC) : (DivbC - n_scaled);
        s1_in    = {qsel, rem, sticky, flags, bus.A, shift};
    end

    fdivsqrt_intresult_stage #(
        .Width (S1W)
    ) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .en        (bus.in_ready),
        .in_valid  (bus.in_valid),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );

    logic [DIVb:0]   s1_qsel;
    logic [W-1:0]    s1_rem;
    logic            s1_sticky;
    op_flags_t       s1_flags;
    logic [XLEN-1:0] s1_a;
    logic [SW-1:0]   s1_shift;

    assign {s1_qsel, s1_rem, s1_sticky, s1_flags, s1_a, s1_shift} = s1_data;

    // Stage 2: sign fix-up, arithmetic normalising shift, special cases
    logic [W-1:0]        q_ext, q, r;
    logic signed [W-1:0] sel;
    logic [XLEN-1:0]     pre, res;
    logic [S2W-1:0]      s2_in, s2_data;

    always_comb begin
        q_ext = {3'b000, s1_qsel};
        q     = s1_flags.neg_quot ? -q_ext : q_ext;
        r     = s1_flags.as_neg ? -s1_rem : s1_rem;
        sel   = s1_flags.rem_op ? r : q;
        pre   = XLEN'(sel >>> s1_shift);
        if (s1_flags.b_zero) begin
            res = s1_flags.rem_op ? s1_a : '1;
        end else if (s1_flags.altb) begin
            res = s1_flags.rem_op ? s1_a : '0;
        end else begin
            res = pre;
        end
        // 32-bit ops on a 64-bit core return a sign-extended word.
        if (XLEN == 64 && s1_flags.w64) begin
            for (int unsigned i = 32; i < XLEN; i++) begin
                res[i] = res[31];
            end
        end
        s2_in = {res, s1_sticky};
    end

    fdivsqrt_intresult_stage #(
        .Width (S2W)
    ) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .en        (s1_adv),
        .in_valid  (s1_valid),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_data  (s2_data)
    );

    assign {bus.Result, bus.Sticky} = s2_data;

endmodule

// File: tb/tb_fdivsqrt_intresult.sv
// Directed bench for fdivsqrt_intresult: a vector table with hand-computed results,
// then back-to-back with backpressure, flush and mid-operation reset sequences.
module tb_fdivsqrt_intresult;
    import fdivsqrt_intresult_pkg::*;

    localparam int W = CFG_DIVB + 4;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    fdivsqrt_intresult_if #(.XLEN(CFG_XLEN), .DIVb(CFG_DIVB)) bus ();

    fdivsqrt_intresult dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] ws, wc, d;
        logic [64:0]  u, um;
        logic [7:0]   n, m;
        logic [63:0]  a;
        logic [5:0]   flags;  // {RemOp, As, NegQuot, BZero, ALTB, W64}
        logic [63:0]  res;
        logic         sticky;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[15];
    vec_t b2b[3];

    function automatic vec_t mk(logic [W-1:0] ws, logic [W-1:0] wc, logic [W-1:0] d,
                                logic [64:0] u, logic [64:0] um, logic [7:0] n,
                                logic [7:0] m, logic [63:0] a, logic [5:0] flags,
                                logic [63:0] res, logic sticky);
        vec_t v;
        v.ws = ws; v.wc = wc; v.d = d; v.u = u; v.um = um; v.n = n; v.m = m;
        v.a = a; v.flags = flags; v.res = res; v.sticky = sticky;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.WS = v.ws; bus.WC = v.wc; bus.D = v.d;
        bus.U = v.u; bus.UM = v.um; bus.n = v.n; bus.m = v.m; bus.A = v.a;
        {bus.RemOp, bus.As, bus.NegQuot, bus.BZero, bus.ALTB, bus.W64} = v.flags;
    endtask

    // One op with out_ready high: checks latency, Result and Sticky.
    task automatic send_check(input string name, input vec_t v);
        int lat;
        @(posedge clk); #1;
        apply(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        check({name, "_result"}, bus.Result, v.res);
        check({name, "_sticky"}, 64'(bus.Sticky), 64'(v.sticky));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sent, recv, cyc;
        logic stall, held;
        logic [63:0] prev;
        int wait_cyc;

        // 100/7: divisor normalised to 7<<4, quotient scaled by 2^4 (n=60, DIVb=64).
        vecs[0]  = mk(-68'sd200, 68'd40, 68'd112, 65'd240, 65'd224, 8'd60, 8'd3, 64'd0,
                      6'b000000, 64'd14, 1'b1);
        vecs[1]  = mk(-68'sd200, 68'd40, 68'd112, 65'd240, 65'd224, 8'd60, 8'd3, 64'd0,
                      6'b100000, 64'd2, 1'b1);
        vecs[2]  = mk(68'd10, 68'd6, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'd0,
                      6'b000000, 64'd15, 1'b1);
        vecs[3]  = mk(68'd10, 68'd6, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'd0,
                      6'b100000, 64'd2, 1'b1);
        vecs[4]  = mk(68'd10, 68'd6, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'd0,
                      6'b001000, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        vecs[5]  = mk(68'd10, 68'd6, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'd0,
                      6'b110000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        vecs[6]  = mk(68'd0, 68'd0, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'd0,
                      6'b000000, 64'd15, 1'b0);
        vecs[7]  = mk(68'd0, 68'd0, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'h1234,
                      6'b000100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vecs[8]  = mk(68'd0, 68'd0, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'h1234,
                      6'b100100, 64'h1234, 1'b0);
        vecs[9]  = mk(68'd0, 68'd0, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'h55,
                      6'b000010, 64'd0, 1'b0);
        vecs[10] = mk(68'd0, 68'd0, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'h55,
                      6'b100010, 64'h55, 1'b0);
        vecs[11] = mk(68'd0, 68'd0, 68'd112, 65'd240, 65'd224, 8'd60, 8'd1, 64'h1234,
                      6'b000110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vecs[12] = mk(68'd0, 68'd0, 68'd0, 65'h8000_0000, 65'd0, 8'd64, 8'd0, 64'd0,
                      6'b000001, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[13] = mk(68'd0, 68'd0, 68'd0, 65'd0, 65'd0, 8'd64, 8'd0, 64'h0000_0001_7FFF_FFFF,
                      6'b100101, 64'h0000_0000_7FFF_FFFF, 1'b0);
        vecs[14] = mk(68'd0, 68'd0, 68'd0, 65'h8000_0000, 65'd0, 8'd64, 8'd0, 64'd0,
                      6'b000000, 64'h0000_0000_8000_0000, 1'b0);
        b2b[0]   = mk(68'd0, 68'd0, 68'd0, 65'h11, 65'd0, 8'd64, 8'd0, 64'd0, 6'b0, 64'h11, 1'b0);
        b2b[1]   = mk(68'd0, 68'd0, 68'd0, 65'h22, 65'd0, 8'd64, 8'd0, 64'd0, 6'b0, 64'h22, 1'b0);
        b2b[2]   = mk(68'd0, 68'd0, 68'd0, 65'h33, 65'd0, 8'd64, 8'd0, 64'd0, 6'b0, 64'h33, 1'b0);

        // Reset state
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        apply(vecs[6]);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.Result, 64'd0);
        check("rst_sticky", 64'(bus.Sticky), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            send_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back with out_ready low in cycles 3..5
        @(posedge clk); #1;
        sent = 0; recv = 0; stall = 1'b0; held = 1'b0; prev = '0;
        for (cyc = 0; cyc < 20 && recv < 3; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            if (held) begin
                check("b2b_hold_valid", 64'(bus.out_valid), 64'd1);
                check("b2b_hold_result", bus.Result, prev);
            end
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 3) begin
                apply(b2b[sent]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.in_ready) stall = 1'b1;
            held = bus.out_valid && !bus.out_ready;
            prev = bus.Result;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("b2b_order%0d", recv), bus.Result, b2b[recv].res);
                recv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid = 1'b0;
        check("b2b_count", 64'(recv), 64'd3);
        check("b2b_stall_seen", 64'(stall), 64'd1);

        // Flush with both stages full; an input offered on the flush cycle is dropped
        @(posedge clk); #1;
        apply(vecs[0]);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        apply(vecs[2]);
        @(posedge clk); #1;
        check("flush_pre_valid", 64'(bus.out_valid), 64'd1);
        apply(vecs[8]);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        check("flush_dropped", 64'(bus.out_valid), 64'd0);
        send_check("post_flush", vecs[3]);

        // Reset while a result is held under backpressure
        @(posedge clk); #1;
        apply(vecs[2]);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_cyc = 0;
        while (!bus.out_valid && wait_cyc < 8) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("rst2_pre_valid", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst2_result", bus.Result, 64'd0);
        check("rst2_sticky", 64'(bus.Sticky), 64'd0);
        check("rst2_in_ready", 64'(bus.in_ready), 64'd1);
        send_check("post_reset", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
